timer_dev: RTL and testbench
============================

# timer_dev

Programmable down-counting timer on the processor's system bus, behind the address bridge. The bridge decodes the CPU's word address, write data and read data onto this block. The block's `IRQ` output feeds CPU hardware interrupt line `HWInt[2]`. It provides one-shot and auto-reload interval timing with a maskable, level-held interrupt.

## Interface
- no parameters
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `Addr`  in  2  word select, from `PrAddr[3:2]`: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved
- `We`  in  1  write strobe; bridge asserts it for one cycle per store to this device
- `Din`  in  32  write data (`PrWD`)
- `Dout`  out  32  read data, combinational from `Addr`; goes to the bridge and becomes `PrRD`
- `IRQ`  out  1  interrupt request, `irq_flag & CTRL.IM`

## Operation
- **Registers**
  - CTRL[0] Enable.
  - CTRL[2:1] Mode: 00 one-shot, 01 auto-reload, 1x treated as 00.
  - CTRL[3] IM (interrupt mask, 1 = enabled).
  - CTRL[31:4] are not stored and read 0.
  - PRESET[31:0] is read/write.
  - COUNT[31:0] is read-only; writes are ignored.
  - Addr 3 reads 0; writes to it are ignored.
- **Write effects**
  - A write to CTRL or PRESET updates that register at the clock edge.
  - Any write to CTRL or PRESET also clears `irq_flag`.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: COUNT holds its value. Goes to LOAD when Enable = 1.
  - LOAD: COUNT <= PRESET. Goes to CNT.
  - CNT, Enable = 0: go to IDLE; COUNT freezes.
  - CNT, COUNT > 1: COUNT <= COUNT − 1; stay in CNT.
  - CNT, COUNT == 1: COUNT <= 0; go to INT.
  - CNT, COUNT == 0 (PRESET was 0): go to INT with no decrement.
  - INT: sets `irq_flag`. In mode 00, hardware clears CTRL.Enable and goes to IDLE. In mode 01, goes to LOAD.
- **irq_flag behaviour**
  - Mode 00: `irq_flag` holds until software writes CTRL or PRESET.
  - Mode 01: `irq_flag` is cleared on the cycle after INT, giving a 1-cycle pulse per period.
- **Write-while-running**
  - A PRESET write while in CNT does not alter COUNT; it takes effect at the next LOAD.
  - Clearing Enable stops counting at the next edge.
- **Simultaneous events**
  - A CTRL write in INT state wins over the hardware Enable clear: the written value is kept, and `irq_flag` ends cleared.
  - A CTRL write with Enable = 0 on the cycle COUNT goes 1→0 wins: next state is IDLE, `irq_flag` stays 0, COUNT = 0.
- **Arithmetic:** unsigned 32-bit. COUNT never wraps below 0.

## Timing
- **Reset:** CTRL = 0, PRESET = 0, COUNT = 0, `irq_flag` = 0, state = IDLE, IRQ = 0. `Dout` reflects the reset values immediately.
- **Reset mid-count:** same reset values; any pending interrupt is lost.
- **Enable write at edge E:** state is IDLE at E+1, LOAD at E+2, and CNT with COUNT = PRESET from E+3.
- **Period for PRESET = N ≥ 1:**
  - Reaches INT N cycles after first entering CNT.
  - IRQ rises one edge later.
  - Mode 01 period = N + 2 cycles (CNT ×N, INT, LOAD).
- **Read:** `Dout` is combinational. A read in the same cycle as a write returns the old value.
- **IRQ:** registered; no combinational path from `Din` or `We`.

## Test plan
- **Reset:** assert `rst` mid-count with COUNT = 5 → all registers 0, IRQ = 0, `Dout` = 0 for Addr 0, 1 and 2.
- **One-shot:** write PRESET = 3, then CTRL = 0x9 → COUNT reads 3, 2, 1, 0. IRQ goes to 1 and stays 1. CTRL reads 0x8. A later write CTRL = 0x8 drops IRQ the next cycle.
- **Auto-reload:** write PRESET = 4, then CTRL = 0xB → IRQ pulses one cycle high every 6 cycles for at least 3 periods. CTRL stays 0xB.
- **Mask:** write CTRL = 0x1 with PRESET = 2 → IRQ never asserts. A later write CTRL = 0x8 clears the pending flag, so IRQ stays 0.
- **PRESET = 0:** write PRESET = 0, then CTRL = 0x9 → INT 1 cycle after entering CNT; COUNT stays 0; IRQ = 1.
- **Disable race:** in mode 01 with COUNT = 1, write CTRL = 0x8 → IRQ stays 0, state IDLE, COUNT = 0. A write to COUNT is ignored.

Source files
------------

// File: rtl/timer_dev.sv
// Programmable down-counting timer on the system bus.
// It supports one-shot and auto-reload modes. IRQ is a maskable, level-held interrupt.
module timer_dev (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

    state_e      state_q, state_d;
    logic        enable_q, enable_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic wr_ctrl;
    logic wr_preset;
    logic auto_reload;
    logic disable_wr;

    assign wr_ctrl     = We && (Addr == 2'd0);
    assign wr_preset   = We && (Addr == 2'd1);
    assign auto_reload = (mode_q == 2'b01);
    // A CTRL write that clears Enable also aborts an expiry that would happen on the same edge.
    assign disable_wr  = wr_ctrl && !Din[0];

    // Next-state and COUNT update for the timer sequencer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (enable_q) state_d = StLoad;
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!enable_q) begin
                    state_d = StIdle;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // COUNT is 1 or 0 here (0 when PRESET was 0); it never wraps.
                    count_d = 32'd0;
                    state_d = disable_wr ? StIdle : StInt;
                end
            end
            StInt: begin
                state_d = auto_reload ? StLoad : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Software-visible registers and the interrupt flag. Software writes win over hardware updates.
    always_comb begin
        enable_d   = enable_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        irq_flag_d = irq_flag_q;

        if (wr_ctrl) begin
            enable_d = Din[0];
            mode_d   = Din[2:1];
            im_d     = Din[3];
        end else if ((state_q == StInt) && !auto_reload) begin
            enable_d = 1'b0;
        end

        if (wr_preset) preset_d = Din;

        if (wr_ctrl || wr_preset) begin
            irq_flag_d = 1'b0;
        end else if (state_q == StInt) begin
            irq_flag_d = 1'b1;
        end else if (auto_reload) begin
            // In auto-reload mode the flag is a single-cycle pulse.
            irq_flag_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            enable_q   <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Combinational read mux. A read in the same cycle as a write sees the old value.
    always_comb begin
        Dout = 32'd0;
        unique case (Addr)
            2'd0:    Dout = {28'd0, im_q, mode_q, enable_q};
            2'd1:    Dout = preset_q;
            2'd2:    Dout = count_q;
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: vector table, directed corner cases, randomized vs model.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  Addr = 2'd0;
    logic        We = 1'b0;
    logic [31:0] Din = 32'd0;
    logic [31:0] Dout;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    timer_dev dut (
        .clk  (clk),
        .rst  (rst),
        .Addr (Addr),
        .We   (We),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        We = 1'b1; Addr = a; Din = d;
        tick();
        We = 1'b0; Din = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        We = 1'b0; Addr = a;
        #1;
        v = Dout;
    endtask

    task automatic do_reset();
        rst = 1'b1; We = 1'b0; Addr = 2'd0; Din = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Reference model: the timer as a sequence of phases (waiting, reloading, counting, expired).
    localparam int PhIdle = 0, PhLoad = 1, PhCount = 2, PhExpired = 3;
    int          m_phase;
    logic        m_en, m_im, m_flag;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;

    task automatic model_reset();
        m_phase = PhIdle; m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
        m_preset = 0; m_count = 0;
    endtask

    function automatic logic [31:0] model_dout(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] d);
        bit          wc = we && (a == 2'd0);
        bit          wp = we && (a == 2'd1);
        bit          periodic = (m_mode == 2'b01);
        int          ph = m_phase;
        logic [31:0] cnt = m_count;
        logic        en = m_en;
        logic        flag = m_flag;
        case (m_phase)
            PhIdle:  if (m_en) ph = PhLoad;
            PhLoad:  begin cnt = m_preset; ph = PhCount; end
            PhCount: begin
                if (!m_en) ph = PhIdle;
                else begin
                    cnt = (m_count == 0) ? 32'd0 : m_count - 1;
                    if (m_count <= 1) ph = (wc && !d[0]) ? PhIdle : PhExpired;
                end
            end
            default: begin
                ph = periodic ? PhLoad : PhIdle;
                if (!periodic) en = 1'b0;
            end
        endcase
        if (wc || wp) flag = 1'b0;
        else if (m_phase == PhExpired) flag = 1'b1;
        else if (periodic) flag = 1'b0;
        if (wc) begin en = d[0]; m_mode = d[2:1]; m_im = d[3]; end
        if (wp) m_preset = d;
        m_phase = ph; m_count = cnt; m_en = en; m_flag = flag;
    endtask

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [0:11];

    initial begin
        logic [31:0] v;
        bit found;
        bit seen;

        // One-shot with PRESET = 3, CTRL = 0x9; each row is one clock cycle.
        vecs[0]  = '{1'b1, 2'd1, 32'd3, 32'd0, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 32'h9, 32'd0, 1'b0};
        vecs[2]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0};
        vecs[3]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 32'd0, 32'd3, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 32'd0, 32'd2, 1'b0};
        vecs[6]  = '{1'b0, 2'd2, 32'd0, 32'd1, 1'b0};
        vecs[7]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 32'd0, 32'h8, 1'b1};
        vecs[9]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b1};
        vecs[10] = '{1'b1, 2'd0, 32'h8, 32'h8, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 32'd0, 32'h8, 1'b0};

        // Reset values, then asynchronous reset mid-count.
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            check("reset_dout", v, 32'd0);
        end
        check("reset_irq", IRQ, 1'b0);
        wr(2'd1, 32'd9);
        wr(2'd0, 32'h9);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            rd(2'd2, v);
            if (v == 32'd5) begin found = 1; break; end
            tick();
        end
        check("rst_reach5", found, 1'b1);
        rst = 1'b1;
        for (int a = 0; a < 3; a++) begin
            rd(a[1:0], v);
            check("rst_mid_dout", v, 32'd0);
        end
        check("rst_mid_irq", IRQ, 1'b0);
        rst = 1'b0;
        tick();

        // Table-driven one-shot.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            We = vecs[i].we; Addr = vecs[i].addr; Din = vecs[i].din;
            #1;
            check($sformatf("vec%0d_dout", i), Dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_irq", i), IRQ, vecs[i].exp_irq);
            tick();
            We = 1'b0;
        end

        // Auto-reload: PRESET = 4 gives a one-cycle pulse every 6 cycles.
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (IRQ) begin found = 1; break; end
            tick();
        end
        check("ar_rise", found, 1'b1);
        for (int k = 0; k < 18; k++) begin
            check("ar_irq", IRQ, (k % 6) == 0);
            tick();
        end
        rd(2'd0, v);
        check("ar_ctrl", v, 32'hB);

        // Mask: IM = 0 keeps IRQ low; a later CTRL write clears the pending flag.
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (IRQ) seen = 1;
            tick();
        end
        check("mask_irq", seen, 1'b0);
        rd(2'd0, v);
        check("mask_ctrl", v, 32'h0);
        wr(2'd0, 32'h8);
        check("mask_after_im", IRQ, 1'b0);
        tick();
        check("mask_after_im2", IRQ, 1'b0);

        // PRESET = 0: expiry one cycle after entering CNT, COUNT stays 0.
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        tick();
        rd(2'd2, v);
        check("p0_cnt_count", v, 32'd0);
        check("p0_cnt_irq", IRQ, 1'b0);
        tick();
        check("p0_int_irq", IRQ, 1'b0);
        tick();
        check("p0_irq", IRQ, 1'b1);
        rd(2'd2, v);
        check("p0_count", v, 32'd0);
        rd(2'd0, v);
        check("p0_ctrl", v, 32'h8);

        // Disable race: CTRL write clearing Enable on the 1 -> 0 edge wins over expiry.
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            rd(2'd2, v);
            if (v == 32'd1) begin
                We = 1'b1; Addr = 2'd0; Din = 32'h8;
                tick();
                We = 1'b0;
                found = 1;
                break;
            end
            tick();
        end
        check("race_reach1", found, 1'b1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (IRQ) seen = 1;
            rd(2'd2, v);
            check("race_count", v, 32'd0);
            tick();
        end
        check("race_irq", seen, 1'b0);
        rd(2'd0, v);
        check("race_ctrl", v, 32'h8);
        wr(2'd2, 32'd55);
        rd(2'd2, v);
        check("count_wr_ignored", v, 32'd0);
        wr(2'd3, 32'd77);
        rd(2'd3, v);
        check("addr3_read", v, 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 800; i++) begin
            We   = ($urandom_range(0, 5) == 0);
            Addr = 2'($urandom_range(0, 3));
            Din  = (Addr == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
            #1;
            check("rand_dout", Dout, model_dout(Addr));
            check("rand_irq", IRQ, m_flag & m_im);
            @(posedge clk);
            model_step(We, Addr, Din);
            #1;
        end
        We = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
